// File: rtl/wt_mem_responder.sv
// wt_mem_responder: memory-side endpoint for the write-through L1 I$/D$
// request interface. Serves one request at a time from a 64-bit-wide array
// and returns a single-cycle response a fixed LATENCY cycles after the ack.
module wt_mem_responder #(
  parameter int LATENCY     = 2,     // 1..15
  parameter int DEPTH_WORDS = 1024,  // power of two
  parameter int LINE_WORDS  = 2,     // power of two, <= DEPTH_WORDS
  parameter int TID_W       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // I$ fill port
  input  logic                    ic_req_i,
  output logic                    ic_ack_o,
  input  logic [63:0]             ic_paddr_i,
  input  logic [TID_W-1:0]        ic_tid_i,
  // D$ load/store port
  input  logic                    dc_req_i,
  output logic                    dc_ack_o,
  input  logic                    dc_rtype_i,
  input  logic                    dc_nc_i,
  input  logic [1:0]              dc_size_i,
  input  logic [63:0]             dc_paddr_i,
  input  logic [63:0]             dc_wdata_i,
  input  logic [TID_W-1:0]        dc_tid_i,
  // return paths
  output logic                    ic_rtrn_vld_o,
  output logic [TID_W-1:0]        ic_rtrn_tid_o,
  output logic [64*LINE_WORDS-1:0] ic_rtrn_data_o,
  output logic                    dc_rtrn_vld_o,
  output logic                    dc_rtrn_type_o,
  output logic [TID_W-1:0]        dc_rtrn_tid_o,
  output logic [64*LINE_WORDS-1:0] dc_rtrn_data_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int DW    = 64 * LINE_WORDS;
  localparam logic [IDX_W-1:0] LINE_MASK = ~IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic {P_IC = 1'b0, P_DC = 1'b1} port_e;

  // Request fields kept for the response phase
  typedef struct packed {
    port_e            port;
    logic             rtype;
    logic             nc;
    logic [IDX_W-1:0] idx;
    logic [TID_W-1:0] tid;
  } hold_t;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  port_e            last_q;
  hold_t            hold_q;
  logic             grant_ic, grant_dc;
  logic             tie;

  logic [63:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] ic_idx, dc_idx, line_base;
  logic [3:0]       st_bytes;
  logic [15:0]      st_be_wide;
  logic [7:0]       st_be;
  logic [DW-1:0]    line_data;

  assign ic_idx = ic_paddr_i[3 +: IDX_W];
  assign dc_idx = dc_paddr_i[3 +: IDX_W];
  assign tie    = ic_req_i && dc_req_i;

  // Byte enables: run of (1<<size) lanes starting at paddr[2:0]; lanes that
  // fall past byte 7 are simply dropped by the truncation.
  assign st_bytes   = 4'd1 << dc_size_i;
  assign st_be_wide = ((16'd1 << st_bytes) - 16'd1) << dc_paddr_i[2:0];
  assign st_be      = st_be_wide[7:0];

  // Address bits above the array and the I$ byte offset carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{ic_paddr_i[63:3+IDX_W], ic_paddr_i[2:0],
                         dc_paddr_i[63:3+IDX_W], st_be_wide[15:8]};

  // Arbitration (IDLE only) and next-state / latency counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tie) begin
          grant_ic = (last_q == P_DC);
          grant_dc = (last_q == P_IC);
        end else begin
          grant_ic = ic_req_i;
          grant_dc = dc_req_i;
        end
        if (grant_ic || grant_dc) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ic_ack_o = grant_ic;
  assign dc_ack_o = grant_dc;

  // FSM state and latency counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the granted request; round-robin pointer only moves on a tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      last_q <= P_DC;
    end else if (grant_ic || grant_dc) begin
      hold_q <= '{port:  (grant_dc ? P_DC : P_IC),
                  rtype: grant_dc & dc_rtype_i,
                  nc:    grant_dc & dc_nc_i,
                  idx:   (grant_dc ? dc_idx : ic_idx),
                  tid:   (grant_dc ? dc_tid_i : ic_tid_i)};
      if (tie) last_q <= grant_dc ? P_DC : P_IC;
    end
  end

  // Store commits on the ack edge so a following load sees the new data
  always_ff @(posedge clk_i) begin
    if (grant_dc && dc_rtype_i) begin
      for (int b = 0; b < 8; b++) begin
        if (st_be[b]) mem[dc_idx][8*b +: 8] <= dc_wdata_i[8*b +: 8];
      end
    end
  end

  assign line_base = hold_q.idx & LINE_MASK;

  // Line-aligned read, word k of the line in bits [64k +: 64]
  always_comb begin
    line_data = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      line_data[64*k +: 64] = mem[line_base + IDX_W'(k)];
    end
  end

  // Return buses: driven only in RESP, zero otherwise
  always_comb begin
    ic_rtrn_vld_o  = 1'b0;
    ic_rtrn_tid_o  = '0;
    ic_rtrn_data_o = '0;
    dc_rtrn_vld_o  = 1'b0;
    dc_rtrn_type_o = 1'b0;
    dc_rtrn_tid_o  = '0;
    dc_rtrn_data_o = '0;
    if (state_q == S_RESP) begin
      if (hold_q.port == P_IC) begin
        ic_rtrn_vld_o  = 1'b1;
        ic_rtrn_tid_o  = hold_q.tid;
        ic_rtrn_data_o = line_data;
      end else begin
        dc_rtrn_vld_o  = 1'b1;
        dc_rtrn_type_o = hold_q.rtype;
        dc_rtrn_tid_o  = hold_q.tid;
        if (!hold_q.rtype) begin
          dc_rtrn_data_o = hold_q.nc ? DW'(mem[hold_q.idx]) : line_data;
        end
      end
    end
  end

endmodule
